// File: rtl/window_sum_sched.sv
// rtl/window_sum_sched.sv - streaming sliding-window adder over a rotating accumulator bank
module window_sum_sched #(
  parameter  int DATA_W  = 8,
  parameter  int MAX_WIN = 4,
  parameter  int SUM_W   = 10,
  parameter  int DEF_WIN = 3,
  localparam int WIN_W   = $clog2(MAX_WIN + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [SUM_W-1:0]  out_sum,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              cfg_load,
  input  logic [WIN_W-1:0]  cfg_win,
  output logic              cfg_err,
  output logic [WIN_W-1:0]  win
);

  localparam int PTR_W = (MAX_WIN > 1) ? $clog2(MAX_WIN) : 1;

  // acc[j] holds the running sum of every sample since slot j last restarted
  logic [SUM_W-1:0] acc [MAX_WIN];
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] ptr_nxt;
  logic [WIN_W-1:0] fill;
  logic [WIN_W-1:0] fill_nxt;
  logic [WIN_W-1:0] win_m1;
  logic [SUM_W-1:0] d_ext;
  logic [SUM_W-1:0] sum_nxt;
  logic             accept;
  logic             cfg_ok;
  logic             fill_full;

  // Handshake, slot rotation and next-window arithmetic
  always_comb begin
    in_ready  = (!out_valid || out_ready) && !cfg_load;
    accept    = in_valid && in_ready;
    cfg_ok    = (cfg_win != '0) && (cfg_win <= WIN_W'(MAX_WIN));
    win_m1    = win - WIN_W'(1);
    fill_full = (fill == win_m1);
    ptr_nxt   = (WIN_W'(ptr) == win_m1) ? '0 : ptr + PTR_W'(1);
    d_ext     = SUM_W'(in_data);
    // The slot after the restarting one already holds the previous win-1
    // samples; a one-sample window has no such slot, so use d directly.
    sum_nxt   = (win == WIN_W'(1)) ? d_ext : acc[ptr_nxt] + d_ext;
    fill_nxt  = fill_full ? fill : fill + WIN_W'(1);
  end

  // Control state: window length, slot pointer, warm-up count, output register
  always_ff @(posedge clk) begin
    if (reset) begin
      win       <= WIN_W'(DEF_WIN);
      ptr       <= '0;
      fill      <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      cfg_err   <= 1'b0;
    end else begin
      cfg_err <= cfg_load && !cfg_ok;
      if (cfg_load && cfg_ok) begin
        win       <= cfg_win;
        ptr       <= '0;
        fill      <= '0;
        out_valid <= 1'b0;
      end else if (accept) begin
        ptr       <= ptr_nxt;
        fill      <= fill_nxt;
        out_sum   <= sum_nxt;
        out_valid <= fill_full;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Accumulator bank: the pointed slot restarts, every other slot adds the sample
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < MAX_WIN; j++) begin
        acc[j] <= '0;
      end
    end else if (accept) begin
      for (int j = 0; j < MAX_WIN; j++) begin
        if (PTR_W'(j) == ptr) begin
          acc[j] <= d_ext;
        end else begin
          acc[j] <= acc[j] + d_ext;
        end
      end
    end
  end

endmodule

// File: tb/tb_window_sum_sched.sv
// tb/tb_window_sum_sched.sv - scoreboard bench for window_sum_sched
module tb_window_sum_sched;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [9:0] out_sum;
  logic       out_valid;
  logic       out_ready;
  logic       cfg_load;
  logic [2:0] cfg_win;
  logic       cfg_err;
  logic [2:0] win;

  logic       in_ready9;
  logic [8:0] out_sum9;
  logic       out_valid9;
  logic       cfg_err9;
  logic [2:0] win9;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int exp9_q[$];

  always #5 clk = ~clk;

  window_sum_sched #(.DATA_W(8), .MAX_WIN(4), .SUM_W(10), .DEF_WIN(3)) u_dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_sum(out_sum), .out_valid(out_valid),
    .out_ready(out_ready), .cfg_load(cfg_load), .cfg_win(cfg_win),
    .cfg_err(cfg_err), .win(win)
  );

  window_sum_sched #(.DATA_W(8), .MAX_WIN(4), .SUM_W(9), .DEF_WIN(3)) u_dut9 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready9), .out_sum(out_sum9), .out_valid(out_valid9),
    .out_ready(out_ready), .cfg_load(cfg_load), .cfg_win(cfg_win),
    .cfg_err(cfg_err9), .win(win9)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pop and compare whenever a result is consumed
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out_sum_unexpected: got %0d expected no output", out_sum);
      end else begin
        chk("out_sum", int'(out_sum), exp_q.pop_front());
      end
    end
    if (out_valid9 && out_ready) begin
      if (exp9_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out_sum9_unexpected: got %0d expected no output", out_sum9);
      end else begin
        chk("out_sum9", int'(out_sum9), exp9_q.pop_front());
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Offer one sample; queue its expected window if it should complete one
  task automatic send(input int d, input bit v, input int e, input bit must_rdy);
    int  cnt;
    bit  first;
    in_data  = 8'(d);
    in_valid = 1'b1;
    cnt      = 0;
    @(negedge clk);
    first = in_ready;
    while (!in_ready && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    if (must_rdy) chk("in_ready_stream", int'(first), 1);
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 within 50 cycles");
    end else if (v) begin
      exp_q.push_back(e);
      exp9_q.push_back(e % 512);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("out_valid_after_accept", int'(out_valid), int'(v));
  endtask

  // One-cycle configuration request, optionally with a sample offered
  task automatic cfg(input int w, input bit offer);
    cfg_load = 1'b1;
    cfg_win  = 3'(w);
    in_valid = offer;
    in_data  = 8'd99;
    @(negedge clk);
    chk("cfg_in_ready", int'(in_ready), 0);
    @(posedge clk);
    #1;
    cfg_load = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cfg_load  = 1'b0;
    cfg_win   = '0;
    @(posedge clk);
    do_reset();

    chk("rst_win", int'(win), 3);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_sum", int'(out_sum), 0);
    chk("rst_cfg_err", int'(cfg_err), 0);
    chk("rst_in_ready", int'(in_ready), 1);

    // Window 3, full throughput
    send(1, 0, 0, 1);
    send(2, 0, 0, 1);
    send(3, 1, 6, 1);
    send(4, 1, 9, 1);
    send(5, 1, 12, 1);
    send(6, 1, 15, 1);
    send(7, 1, 18, 1);
    repeat (2) @(posedge clk);

    // Back-pressure after the first valid result
    do_reset();
    send(1, 0, 0, 1);
    send(2, 0, 0, 1);
    send(3, 1, 6, 1);
    out_ready = 1'b0;
    in_data   = 8'd4;
    in_valid  = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_out_sum_hold", int'(out_sum), 6);
      chk("bp_out_valid_hold", int'(out_valid), 1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(4, 1, 9, 0);
    send(5, 1, 12, 1);
    send(6, 1, 15, 1);
    send(7, 1, 18, 1);
    repeat (2) @(posedge clk);

    // Reset mid-stream after sample 5
    do_reset();
    send(1, 0, 0, 1);
    send(2, 0, 0, 1);
    send(3, 1, 6, 1);
    send(4, 1, 9, 1);
    send(5, 1, 12, 1);
    do_reset();
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_win", int'(win), 3);
    chk("midrst_out_sum", int'(out_sum), 0);
    send(1, 0, 0, 1);
    send(1, 0, 0, 1);
    send(1, 1, 3, 1);
    repeat (2) @(posedge clk);

    // Reconfigure to window 4 while a sample is offered
    do_reset();
    send(1, 0, 0, 1);
    send(2, 0, 0, 1);
    send(3, 1, 6, 1);
    send(4, 1, 9, 1);
    cfg(4, 1);
    chk("cfg4_win", int'(win), 4);
    chk("cfg4_out_valid", int'(out_valid), 0);
    chk("cfg4_cfg_err", int'(cfg_err), 0);
    send(10, 0, 0, 1);
    send(20, 0, 0, 1);
    send(30, 0, 0, 1);
    send(40, 1, 100, 1);
    send(50, 1, 140, 1);
    repeat (2) @(posedge clk);

    // Window 1, then illegal lengths 0 and 5
    cfg(1, 0);
    chk("cfg1_win", int'(win), 1);
    send(7, 1, 7, 1);
    send(9, 1, 9, 1);
    cfg(0, 0);
    chk("cfg0_err_pulse", int'(cfg_err), 1);
    chk("cfg0_win_kept", int'(win), 1);
    @(posedge clk);
    #1;
    chk("cfg0_err_clear", int'(cfg_err), 0);
    cfg(5, 0);
    chk("cfg5_err_pulse", int'(cfg_err), 1);
    chk("cfg5_win_kept", int'(win), 1);
    send(3, 1, 3, 1);
    repeat (2) @(posedge clk);

    // Wrap: four and five samples of 255 in window 4
    cfg(4, 0);
    send(255, 0, 0, 1);
    send(255, 0, 0, 1);
    send(255, 0, 0, 1);
    send(255, 1, 1020, 1);
    send(255, 1, 1020, 1);
    repeat (4) @(posedge clk);

    chk("scoreboard_drained", exp_q.size(), 0);
    chk("scoreboard9_drained", exp9_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
